// File: rtl/pixel_stream_sink.sv
// -----------------------------------------------------------------------------
// pixel_stream_sink
//
// Receiving end of the generator's pixel stream. Beats arrive on a valid/ready
// handshake tagged with start-of-frame (sop) and end-of-frame (eop). They are
// buffered in a small FIFO and then replayed as linear-address writes into a
// frame buffer. The sink rebuilds the raster position itself. It flags framing
// errors, resynchronises on the next sop, and counts completed frames.
//
// Ports
//   clk          clock, all logic on the rising edge
//   reset        asynchronous active-low reset (0 = reset)
//   in_valid     input beat present
//   in_ready     sink can accept a beat (registered, = FIFO not full)
//   in_colour    pixel colour
//   in_sop       beat is the first pixel of a frame
//   in_eop       beat is the last pixel of a frame
//   wr_en        frame buffer write request (held until wr_ready)
//   wr_addr      linear address y*SCREEN_WIDTH+x
//   wr_data      colour to write
//   wr_ready     frame buffer accepts the write this cycle
//   frame_done   one-cycle pulse: a complete frame was written
//   err          one-cycle pulse: framing error detected
//   frame_count  completed-frame counter, wraps 255 -> 0
// -----------------------------------------------------------------------------
module pixel_stream_sink #(
    parameter int DATA_WIDTH    = 10,
    parameter int RBG_SIZE      = 24,
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int FIFO_DEPTH    = 4,
    parameter int ADDR_WIDTH    = 19
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [RBG_SIZE-1:0]   in_colour,
    input  logic                  in_sop,
    input  logic                  in_eop,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [RBG_SIZE-1:0]   wr_data,
    input  logic                  wr_ready,
    output logic                  frame_done,
    output logic                  err,
    output logic [7:0]            frame_count
);

    localparam int ENTRY_W = RBG_SIZE + 2;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;

    localparam logic [CNT_W-1:0]      FIFO_FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [DATA_WIDTH-1:0] X_LAST        = DATA_WIDTH'(SCREEN_WIDTH - 1);
    localparam logic [DATA_WIDTH-1:0] Y_LAST        = DATA_WIDTH'(SCREEN_HEIGHT - 1);

    localparam logic [1:0] ST_WAIT_SOP = 2'd0;
    localparam logic [1:0] ST_RECV     = 2'd1;
    localparam logic [1:0] ST_DROP     = 2'd2;

    // -------------------------------------------------------------------------
    // Input FIFO
    // -------------------------------------------------------------------------
    logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [CNT_W-1:0]   count_next;
    logic               in_ready_reg;

    logic               push;
    logic               pop;
    logic               head_valid;
    logic [RBG_SIZE-1:0] head_colour;
    logic               head_sop;
    logic               head_eop;

    // in_ready_reg always reflects "not full" for the current count, so a
    // full FIFO never accepts a beat even when it pops in the same cycle.
    assign push       = in_valid && in_ready_reg;
    assign head_valid = (count_reg != '0);
    assign {head_colour, head_sop, head_eop} = fifo_mem[rd_ptr_reg];

    // Storage holds no control state, so it needs no reset; each entry is
    // written only when the write pointer selects it.
    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_fifo_entry
            always_ff @(posedge clk) begin
                if (push && (wr_ptr_reg == PTR_W'(gi))) begin
                    fifo_mem[gi] <= {in_colour, in_sop, in_eop};
                end
            end
        end
    endgenerate

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            in_ready_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg    <= count_next;
            in_ready_reg <= (count_next != FIFO_FULL_CNT);
        end
    end

    // -------------------------------------------------------------------------
    // Framing FSM and raster position
    // -------------------------------------------------------------------------
    logic [1:0]            state_reg;
    logic [1:0]            state_next;
    logic [DATA_WIDTH-1:0] x_reg;
    logic [DATA_WIDTH-1:0] x_next;
    logic [DATA_WIDTH-1:0] y_reg;
    logic [DATA_WIDTH-1:0] y_next;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [ADDR_WIDTH-1:0] addr_next;
    // Set once a stray beat has been reported in WAIT_SOP, so a run of
    // stray beats raises a single err pulse.
    logic                  stray_seen_reg;
    logic                  stray_seen_next;

    logic                  wr_en_reg;
    logic [ADDR_WIDTH-1:0] wr_addr_reg;
    logic [RBG_SIZE-1:0]   wr_data_reg;
    logic                  frame_done_reg;
    logic                  err_reg;
    logic [7:0]            frame_count_reg;

    logic                  out_free;
    logic                  do_write;
    logic                  set_done;
    logic                  set_err;
    logic [DATA_WIDTH-1:0] pos_x;
    logic [DATA_WIDTH-1:0] pos_y;
    logic [ADDR_WIDTH-1:0] pix_addr;
    logic                  is_last;

    // The output register can take a new pixel when it is empty or when its
    // current write completes on this edge.
    assign out_free = !wr_en_reg || wr_ready;

    always_comb begin
        pop             = 1'b0;
        do_write        = 1'b0;
        set_done        = 1'b0;
        set_err         = 1'b0;
        state_next      = state_reg;
        x_next          = x_reg;
        y_next          = y_reg;
        addr_next       = addr_reg;
        stray_seen_next = stray_seen_reg;
        pos_x           = x_reg;
        pos_y           = y_reg;
        pix_addr        = addr_reg;
        is_last         = 1'b0;

        if (head_valid) begin
            if (head_sop || (state_reg == ST_RECV)) begin
                // Beat that becomes a write: wait for room in the output reg.
                if (out_free) begin
                    pop      = 1'b1;
                    do_write = 1'b1;
                    if (head_sop) begin
                        // A sop always restarts the raster at the origin. In
                        // RECV this means the previous frame was cut short.
                        pos_x           = '0;
                        pos_y           = '0;
                        pix_addr        = '0;
                        stray_seen_next = 1'b0;
                        if (state_reg == ST_RECV) begin
                            set_err = 1'b1;
                        end
                    end

                    is_last   = (pos_x == X_LAST) && (pos_y == Y_LAST);
                    addr_next = pix_addr + ADDR_WIDTH'(1);
                    if (pos_x == X_LAST) begin
                        x_next = '0;
                        y_next = (pos_y == Y_LAST) ? '0 : pos_y + DATA_WIDTH'(1);
                    end else begin
                        x_next = pos_x + DATA_WIDTH'(1);
                        y_next = pos_y;
                    end

                    if (is_last && head_eop) begin
                        set_done   = 1'b1;
                        state_next = ST_WAIT_SOP;
                    end else if (is_last) begin
                        // Frame overran its size: drop until its eop shows up.
                        set_err    = 1'b1;
                        state_next = ST_DROP;
                    end else if (head_eop) begin
                        set_err    = 1'b1;
                        state_next = ST_WAIT_SOP;
                    end else begin
                        state_next = ST_RECV;
                    end
                end
            end else begin
                // Discarded beats do not touch the output register, so they
                // drain even while the frame buffer is stalling.
                pop = 1'b1;
                if (state_reg == ST_DROP) begin
                    if (head_eop) begin
                        state_next = ST_WAIT_SOP;
                    end
                end else if (!stray_seen_reg) begin
                    set_err         = 1'b1;
                    stray_seen_next = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= ST_WAIT_SOP;
            x_reg           <= '0;
            y_reg           <= '0;
            addr_reg        <= '0;
            stray_seen_reg  <= 1'b0;
            wr_en_reg       <= 1'b0;
            wr_addr_reg     <= '0;
            wr_data_reg     <= '0;
            frame_done_reg  <= 1'b0;
            err_reg         <= 1'b0;
            frame_count_reg <= '0;
        end else begin
            state_reg      <= state_next;
            x_reg          <= x_next;
            y_reg          <= y_next;
            addr_reg       <= addr_next;
            stray_seen_reg <= stray_seen_next;
            frame_done_reg <= set_done;
            err_reg        <= set_err;

            if (do_write) begin
                wr_en_reg   <= 1'b1;
                wr_addr_reg <= pix_addr;
                wr_data_reg <= head_colour;
            end else if (wr_ready) begin
                wr_en_reg <= 1'b0;
            end

            if (set_done) begin
                frame_count_reg <= frame_count_reg + 8'd1;
            end
        end
    end

    assign in_ready    = in_ready_reg;
    assign wr_en       = wr_en_reg;
    assign wr_addr     = wr_addr_reg;
    assign wr_data     = wr_data_reg;
    assign frame_done  = frame_done_reg;
    assign err         = err_reg;
    assign frame_count = frame_count_reg;

endmodule

// File: tb/tb_pixel_stream_sink.sv
// -----------------------------------------------------------------------------
// tb_pixel_stream_sink
//
// Directed bench for pixel_stream_sink on a 4x3 screen. Expected writes are
// queued as beats are driven and popped when each new write appears on wr_en.
// -----------------------------------------------------------------------------
module tb_pixel_stream_sink;

    localparam int W   = 4;
    localparam int H   = 3;
    localparam int DW  = 10;
    localparam int RBG = 24;
    localparam int FD  = 4;
    localparam int AW  = 19;
    localparam int NPX = W * H;

    logic           clk;
    logic           reset;
    logic           in_valid;
    logic           in_ready;
    logic [RBG-1:0] in_colour;
    logic           in_sop;
    logic           in_eop;
    logic           wr_en;
    logic [AW-1:0]  wr_addr;
    logic [RBG-1:0] wr_data;
    logic           wr_ready;
    logic           frame_done;
    logic           err;
    logic [7:0]     frame_count;

    pixel_stream_sink #(
        .DATA_WIDTH    (DW),
        .RBG_SIZE      (RBG),
        .SCREEN_WIDTH  (W),
        .SCREEN_HEIGHT (H),
        .FIFO_DEPTH    (FD),
        .ADDR_WIDTH    (AW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_colour   (in_colour),
        .in_sop      (in_sop),
        .in_eop      (in_eop),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .frame_done  (frame_done),
        .err         (err),
        .frame_count (frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0]  addr;
        logic [RBG-1:0] data;
        logic           done;
        logic           err;
    } exp_t;

    exp_t           exp_q[$];
    int             vectors     = 0;
    int             miscompares = 0;
    int             stray_errs  = 0;
    int             exp_fc      = 0;
    int             wr_mode     = 0;   // 0: ready, 1: toggle, 2: stalled
    bit             saw_full    = 1'b0;
    logic           prev_en     = 1'b0;
    logic           prev_ready  = 1'b0;
    logic [AW-1:0]  prev_addr   = '0;
    logic [RBG-1:0] prev_data   = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input int a, input logic [RBG-1:0] d, input bit dn, input bit er);
        exp_t e;
        e.addr = AW'(a);
        e.data = d;
        e.done = dn;
        e.err  = er;
        exp_q.push_back(e);
    endtask

    // Drives one beat and returns just after the edge that accepted it.
    task automatic send(input logic [RBG-1:0] c, input bit s, input bit e);
        bit got = 1'b0;
        in_valid  = 1'b1;
        in_colour = c;
        in_sop    = s;
        in_eop    = e;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
        check("beat_accepted", 64'(got), 64'd1);
    endtask

    task automatic frame_good();
        logic [RBG-1:0] c;
        for (int i = 0; i < NPX; i++) begin
            c = RBG'($urandom);
            push_exp(i, c, (i == NPX - 1), 1'b0);
            send(c, (i == 0), (i == NPX - 1));
        end
        exp_fc++;
    endtask

    task automatic drain(input string tag);
        bit ok = 1'b0;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !wr_en) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (3) @(negedge clk);
        check({tag, "_drained"}, 64'(ok), 64'd1);
        @(posedge clk);
        #1;
    endtask

    // Frame buffer ready driver.
    initial begin
        wr_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            wr_ready = (wr_mode == 0) ? 1'b1 : (wr_mode == 1) ? ~wr_ready : 1'b0;
        end
    end

    // Output monitor: a write "appears" when wr_en rises or follows a
    // completed write; otherwise a held wr_en must stay stable.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (wr_en) begin
                    if (!prev_en || prev_ready) begin
                        check("write_expected", 64'(exp_q.size() != 0), 64'd1);
                        if (exp_q.size() != 0) begin
                            e = exp_q.pop_front();
                            $display("write addr=%0d data=%06h done=%0b err=%0b", wr_addr, wr_data, frame_done, err);
                            check("wr_addr", 64'(wr_addr), 64'(e.addr));
                            check("wr_data", 64'(wr_data), 64'(e.data));
                            check("frame_done", 64'(frame_done), 64'(e.done));
                            check("err_with_write", 64'(err), 64'(e.err));
                        end
                    end else begin
                        check("stall_addr", 64'(wr_addr), 64'(prev_addr));
                        check("stall_data", 64'(wr_data), 64'(prev_data));
                        check("stall_pulses", 64'({frame_done, err}), 64'd0);
                    end
                end else begin
                    if (err) stray_errs++;
                    check("done_without_write", 64'(frame_done), 64'd0);
                end
                if (in_valid && !in_ready) saw_full = 1'b1;
            end
            prev_en    = wr_en;
            prev_ready = wr_ready;
            prev_addr  = wr_addr;
            prev_data  = wr_data;
        end
    end

    initial begin
        logic [RBG-1:0] c;
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_colour = '0;
        in_sop    = 1'b0;
        in_eop    = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_outputs", 64'({wr_en, frame_done, err}), 64'd0);
        check("rst_wr_addr", 64'(wr_addr), 64'd0);
        check("rst_wr_data", 64'(wr_data), 64'd0);
        check("rst_frame_count", 64'(frame_count), 64'd0);
        reset = 1'b1;
        #1;
        check("release_in_ready_low", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        check("release_in_ready_high", 64'(in_ready), 64'd1);

        // 1: clean frame at full rate
        frame_good();
        drain("t1");
        check("t1_frame_count", 64'(frame_count), 64'(exp_fc));
        check("t1_stray_err", 64'(stray_errs), 64'd0);

        // 2: clean frame with frame buffer stalling every other cycle
        wr_mode  = 1;
        saw_full = 1'b0;
        frame_good();
        drain("t2");
        wr_mode = 0;
        check("t2_in_ready_dropped", 64'(saw_full), 64'd1);
        check("t2_frame_count", 64'(frame_count), 64'(exp_fc));

        // 3: early eop on beat 7, then a clean frame
        for (int i = 0; i < 8; i++) begin
            c = RBG'($urandom);
            push_exp(i, c, 1'b0, (i == 7));
            send(c, (i == 0), (i == 7));
        end
        frame_good();
        drain("t3");
        check("t3_frame_count", 64'(frame_count), 64'(exp_fc));
        check("t3_stray_err", 64'(stray_errs), 64'd0);

        // 4: missing eop on last pixel, eop arrives on beat 13
        for (int i = 0; i < NPX + 2; i++) begin
            c = RBG'($urandom);
            if (i < NPX) push_exp(i, c, 1'b0, (i == NPX - 1));
            send(c, (i == 0), (i == NPX + 1));
        end
        frame_good();
        drain("t4");
        check("t4_frame_count", 64'(frame_count), 64'(exp_fc));
        check("t4_stray_err", 64'(stray_errs), 64'd0);

        // 5: three stray beats before a frame
        stray_errs = 0;
        for (int i = 0; i < 3; i++) begin
            send(RBG'($urandom), 1'b0, 1'b0);
        end
        frame_good();
        drain("t5");
        check("t5_single_err", 64'(stray_errs), 64'd1);
        check("t5_frame_count", 64'(frame_count), 64'(exp_fc));

        // 6: reset mid-frame with a pending write and a buffered beat
        for (int i = 0; i < 5; i++) begin
            c = RBG'($urandom);
            push_exp(i, c, 1'b0, 1'b0);
            send(c, (i == 0), 1'b0);
        end
        drain("t6a");
        wr_mode = 2;
        repeat (2) @(posedge clk);
        #2;
        c = RBG'($urandom);
        push_exp(5, c, 1'b0, 1'b0);
        send(c, 1'b0, 1'b0);
        send(RBG'($urandom), 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("t6_pending_write", 64'({wr_en, 5'(exp_q.size())}), 64'h20);
        #2;
        reset = 1'b0;
        #1;
        check("t6_rst_outputs", 64'({wr_en, frame_done, err, in_ready}), 64'd0);
        check("t6_rst_wr_addr", 64'(wr_addr), 64'd0);
        check("t6_rst_wr_data", 64'(wr_data), 64'd0);
        check("t6_rst_frame_count", 64'(frame_count), 64'd0);
        exp_q.delete();
        exp_fc  = 0;
        wr_mode = 0;
        stray_errs = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("t6_in_ready_low", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        check("t6_in_ready_high", 64'(in_ready), 64'd1);
        frame_good();
        drain("t6b");
        check("t6_frame_count", 64'(frame_count), 64'(exp_fc));
        check("t6_stray_err", 64'(stray_errs), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
